// File: rtl/lc3_dmem_responder_if.sv
// ---------------------------------------------------------------------------
// lc3_dmem_responder_if
//   Data-memory request/response bundle between the LC3 memaccess stage
//   (master) and the data-memory responder (slave).
//
//   data_req      master->slave  request strobe
//   Data_rd       master->slave  1 = read, 0 = write
//   Data_addr     master->slave  16-bit word address
//   Data_din      master->slave  write data
//   Data_dout     slave->master  read data, valid with complete_data on a read
//   complete_data slave->master  one-cycle completion pulse
//   busy          slave->master  request outstanding
//   proto_err     slave->master  sticky: request arrived while busy
// ---------------------------------------------------------------------------
interface lc3_dmem_responder_if;
    logic        data_req;
    logic        Data_rd;
    logic [15:0] Data_addr;
    logic [15:0] Data_din;
    logic [15:0] Data_dout;
    logic        complete_data;
    logic        busy;
    logic        proto_err;

    modport master (
        output data_req,
        output Data_rd,
        output Data_addr,
        output Data_din,
        input  Data_dout,
        input  complete_data,
        input  busy,
        input  proto_err
    );

    modport slave (
        input  data_req,
        input  Data_rd,
        input  Data_addr,
        input  Data_din,
        output Data_dout,
        output complete_data,
        output busy,
        output proto_err
    );
endinterface

// File: rtl/lc3_dmem_responder.sv
// ---------------------------------------------------------------------------
// lc3_dmem_responder
//   Memory-side responder for the LC3 data-memory interface. Accepts one
//   read or write at a time, services it from an internal 16-bit word array
//   after LATENCY cycles and signals completion with a one-cycle pulse.
//
//   clock         rising-edge clock
//   reset         synchronous, active-high reset (memory is not cleared)
//   dmem          request/response bundle (slave side)
//   preload_en    backdoor write enable, any state, does not touch the FSM
//   preload_addr  backdoor word address
//   preload_data  backdoor write data
// ---------------------------------------------------------------------------
module lc3_dmem_responder #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    lc3_dmem_responder_if.slave   dmem,
    input  logic                  preload_en,
    input  logic [DEPTH_LOG2-1:0] preload_addr,
    input  logic [15:0]           preload_data
);

    localparam int unsigned Depth  = 1 << DEPTH_LOG2;
    localparam logic [3:0]  LatCnt = 4'(LATENCY);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("lc3_dmem_responder: LATENCY must be in 1..15");
    end
    if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 15) begin : g_bad_depth
        $error("lc3_dmem_responder: DEPTH_LOG2 must be in 1..15");
    end

    typedef logic [DEPTH_LOG2-1:0] addr_t;
    typedef enum logic {StIdle, StWait} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rd_q, rd_d;
    addr_t       addr_q, addr_d;
    logic [15:0] din_q, din_d;
    logic [15:0] dout_q, dout_d;
    logic        cmp_q, cmp_d;
    logic        busy_q, busy_d;
    logic        perr_q, perr_d;

    logic [15:0] mem_q [Depth];

    logic        done_cycle;
    logic        accept;
    logic        wr_now;
    logic [15:0] rd_fwd;

    // Upper address bits alias onto the array and are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^dmem.Data_addr[15:DEPTH_LOG2];

    // The completion cycle is the last WAIT cycle; a new request may be taken then.
    assign done_cycle = (state_q == StWait) && (cnt_q == 4'd1);
    assign accept     = dmem.data_req && ((state_q == StIdle) || done_cycle);
    // Reset aborts an outstanding write even in its completion cycle.
    assign wr_now     = done_cycle && !rd_q && !reset;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        din_d   = din_q;
        dout_d  = dout_q;
        perr_d  = perr_q | (dmem.data_req && (state_q == StWait) && !done_cycle);

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StWait;
                    cnt_d   = LatCnt;
                    rd_d    = dmem.Data_rd;
                    addr_d  = dmem.Data_addr[DEPTH_LOG2-1:0];
                    din_d   = dmem.Data_din;
                end
            end
            StWait: begin
                if (done_cycle) begin
                    if (accept) begin
                        cnt_d  = LatCnt;
                        rd_d   = dmem.Data_rd;
                        addr_d = dmem.Data_addr[DEPTH_LOG2-1:0];
                        din_d  = dmem.Data_din;
                    end else begin
                        state_d = StIdle;
                        cnt_d   = 4'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase

        busy_d = (state_d == StWait);
        cmp_d  = (state_d == StWait) && (cnt_d == 4'd1);

        // Read data is captured one cycle ahead of the completion pulse, so any
        // memory update landing at the end of this cycle is forwarded; a preload
        // overrides a completing write to the same word.
        rd_fwd = mem_q[addr_d];
        if (wr_now && (addr_q == addr_d)) begin
            rd_fwd = din_q;
        end
        if (preload_en && (preload_addr == addr_d)) begin
            rd_fwd = preload_data;
        end
        if (cmp_d && rd_d) begin
            dout_d = rd_fwd;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= 16'd0;
            dout_q  <= 16'd0;
            cmp_q   <= 1'b0;
            busy_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            cmp_q   <= cmp_d;
            busy_q  <= busy_d;
            perr_q  <= perr_d;
        end
    end

    // Preload is written last so it wins over a completing write to the same word.
    always_ff @(posedge clock) begin
        if (wr_now) begin
            mem_q[addr_q] <= din_q;
        end
        if (preload_en) begin
            mem_q[preload_addr] <= preload_data;
        end
    end

    assign dmem.Data_dout     = dout_q;
    assign dmem.complete_data = cmp_q;
    assign dmem.busy          = busy_q;
    assign dmem.proto_err     = perr_q;

endmodule

// File: tb/tb_lc3_dmem_responder.sv
// Bench for lc3_dmem_responder: three instances with LATENCY 1, 2 and 3,
// directed scenarios plus randomized traffic against a transaction-level model.
module tb_lc3_dmem_responder;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst     [3];
    logic        req     [3];
    logic        rd      [3];
    logic [15:0] addr    [3];
    logic [15:0] din     [3];
    logic        pl_en   [3];
    logic [7:0]  pl_addr [3];
    logic [15:0] pl_data [3];
    logic [15:0] dout    [3];
    logic        cmp     [3];
    logic        busy    [3];
    logic        perr    [3];

    logic [15:0] model_mem [3][256];

    int checks   = 0;
    int failures = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        lc3_dmem_responder_if bus();
        assign bus.data_req  = req[g];
        assign bus.Data_rd   = rd[g];
        assign bus.Data_addr = addr[g];
        assign bus.Data_din  = din[g];
        assign dout[g]       = bus.Data_dout;
        assign cmp[g]        = bus.complete_data;
        assign busy[g]       = bus.busy;
        assign perr[g]       = bus.proto_err;

        lc3_dmem_responder #(
            .DEPTH_LOG2 (8),
            .LATENCY    (g + 1)
        ) u_dut (
            .clock        (clock),
            .reset        (rst[g]),
            .dmem         (bus.slave),
            .preload_en   (pl_en[g]),
            .preload_addr (pl_addr[g]),
            .preload_data (pl_data[g])
        );
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs(input int d);
        req[d]     = 1'b0;
        rd[d]      = 1'b0;
        addr[d]    = 16'd0;
        din[d]     = 16'd0;
        pl_en[d]   = 1'b0;
        pl_addr[d] = 8'd0;
        pl_data[d] = 16'd0;
    endtask

    task automatic do_reset(input int d);
        idle_inputs(d);
        rst[d] = 1'b1;
        step();
        step();
        rst[d] = 1'b0;
    endtask

    task automatic preload(input int d, input int a, input logic [15:0] v);
        pl_en[d]   = 1'b1;
        pl_addr[d] = 8'(a);
        pl_data[d] = v;
        step();
        pl_en[d] = 1'b0;
        model_mem[d][a] = v;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) rst[d] = 1'b1;
        step();
        step();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (dout[d] !== 16'd0) begin
                failures++;
                $display("FAIL reset_dout dut%0d got=%h exp=0000", d, dout[d]);
            end
            checks++;
            if (cmp[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_cmp dut%0d got=%b exp=0", d, cmp[d]);
            end
            checks++;
            if (busy[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_busy dut%0d got=%b exp=0", d, busy[d]);
            end
            checks++;
            if (perr[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_perr dut%0d got=%b exp=0", d, perr[d]);
            end
        end
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    endtask

    // LATENCY=2 read: completion only in cycle 2, busy in cycles 1..2.
    task automatic test_read_basic();
        preload(1, 'h10, 16'hBEEF);
        req[1] = 1'b1; rd[1] = 1'b1; addr[1] = 16'h0010;
        step();
        req[1] = 1'b0;
        checks++;
        if (cmp[1] !== 1'b0 || busy[1] !== 1'b1) begin
            failures++;
            $display("FAIL read_c1 cmp/busy got=%b/%b exp=0/1", cmp[1], busy[1]);
        end
        step();
        checks++;
        if (cmp[1] !== 1'b1 || busy[1] !== 1'b1) begin
            failures++;
            $display("FAIL read_c2 cmp/busy got=%b/%b exp=1/1", cmp[1], busy[1]);
        end
        checks++;
        if (dout[1] !== 16'hBEEF) begin
            failures++;
            $display("FAIL read_c2_dout got=%h exp=beef", dout[1]);
        end
        step();
        checks++;
        if (cmp[1] !== 1'b0 || busy[1] !== 1'b0 || dout[1] !== 16'hBEEF) begin
            failures++;
            $display("FAIL read_c3 cmp/busy/dout got=%b/%b/%h exp=0/0/beef",
                     cmp[1], busy[1], dout[1]);
        end
    endtask

    // Write, then read the same word in the write's completion cycle.
    task automatic test_write_read();
        req[1] = 1'b1; rd[1] = 1'b0; addr[1] = 16'h0020; din[1] = 16'h1234;
        step();
        req[1] = 1'b0;
        step();
        checks++;
        if (cmp[1] !== 1'b1) begin
            failures++;
            $display("FAIL wr_complete got=%b exp=1", cmp[1]);
        end
        req[1] = 1'b1; rd[1] = 1'b1; addr[1] = 16'h0020;
        step();
        req[1] = 1'b0;
        checks++;
        if (cmp[1] !== 1'b0 || busy[1] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_mid cmp/busy got=%b/%b exp=0/1", cmp[1], busy[1]);
        end
        step();
        checks++;
        if (cmp[1] !== 1'b1 || dout[1] !== 16'h1234) begin
            failures++;
            $display("FAIL b2b_read cmp/dout got=%b/%h exp=1/1234", cmp[1], dout[1]);
        end
        checks++;
        if (perr[1] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_perr got=%b exp=0", perr[1]);
        end
        step();
        checks++;
        if (busy[1] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle_busy got=%b exp=0", busy[1]);
        end
    endtask

    // LATENCY=3: second strobe in cycle 1 is ignored and flags an error.
    task automatic test_proto_err();
        int ncmp;
        do_reset(2);
        req[2] = 1'b1; rd[2] = 1'b1; addr[2] = 16'h0007;
        step();
        checks++;
        if (perr[2] !== 1'b0) begin
            failures++;
            $display("FAIL perr_c1 got=%b exp=0", perr[2]);
        end
        step();
        req[2] = 1'b0;
        checks++;
        if (perr[2] !== 1'b1 || cmp[2] !== 1'b0) begin
            failures++;
            $display("FAIL perr_c2 perr/cmp got=%b/%b exp=1/0", perr[2], cmp[2]);
        end
        step();
        checks++;
        if (cmp[2] !== 1'b1) begin
            failures++;
            $display("FAIL perr_c3_cmp got=%b exp=1", cmp[2]);
        end
        ncmp = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (cmp[2] === 1'b1) ncmp++;
        end
        checks++;
        if (ncmp != 0 || perr[2] !== 1'b1) begin
            failures++;
            $display("FAIL perr_extra cmp_count/perr got=%0d/%b exp=0/1", ncmp, perr[2]);
        end
    endtask

    task automatic test_alias();
        req[1] = 1'b1; rd[1] = 1'b0; addr[1] = 16'h0105; din[1] = 16'hAAAA;
        step();
        req[1] = 1'b0;
        step();
        step();
        req[1] = 1'b1; rd[1] = 1'b1; addr[1] = 16'h0005;
        step();
        req[1] = 1'b0;
        step();
        checks++;
        if (cmp[1] !== 1'b1 || dout[1] !== 16'hAAAA) begin
            failures++;
            $display("FAIL alias cmp/dout got=%b/%h exp=1/aaaa", cmp[1], dout[1]);
        end
    endtask

    // Preload in the completion cycle of a write to the same word wins.
    task automatic test_preload_wins();
        req[1] = 1'b1; rd[1] = 1'b0; addr[1] = 16'h0050; din[1] = 16'h1111;
        step();
        req[1] = 1'b0;
        step();
        pl_en[1] = 1'b1; pl_addr[1] = 8'h50; pl_data[1] = 16'h2222;
        step();
        pl_en[1] = 1'b0;
        req[1] = 1'b1; rd[1] = 1'b1; addr[1] = 16'h0050;
        step();
        req[1] = 1'b0;
        step();
        checks++;
        if (cmp[1] !== 1'b1 || dout[1] !== 16'h2222) begin
            failures++;
            $display("FAIL preload_wins cmp/dout got=%b/%h exp=1/2222", cmp[1], dout[1]);
        end
    endtask

    task automatic test_reset_abort();
        int ncmp;
        preload(1, 'h30, 16'h0001);
        req[1] = 1'b1; rd[1] = 1'b0; addr[1] = 16'h0030; din[1] = 16'h5555;
        step();
        req[1] = 1'b0;
        rst[1] = 1'b1;
        step();
        rst[1] = 1'b0;
        checks++;
        if (dout[1] !== 16'd0 || cmp[1] !== 1'b0 || busy[1] !== 1'b0 || perr[1] !== 1'b0) begin
            failures++;
            $display("FAIL abort_outputs dout/cmp/busy/perr got=%h/%b/%b/%b exp=0000/0/0/0",
                     dout[1], cmp[1], busy[1], perr[1]);
        end
        ncmp = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (cmp[1] === 1'b1) ncmp++;
        end
        checks++;
        if (ncmp != 0) begin
            failures++;
            $display("FAIL abort_no_cmp got=%0d exp=0", ncmp);
        end
        req[1] = 1'b1; rd[1] = 1'b1; addr[1] = 16'h0030;
        step();
        req[1] = 1'b0;
        step();
        checks++;
        if (cmp[1] !== 1'b1 || dout[1] !== 16'h0001) begin
            failures++;
            $display("FAIL abort_readback cmp/dout got=%b/%h exp=1/0001", cmp[1], dout[1]);
        end
    endtask

    // LATENCY=1: four reads back to back, preload during the last completion.
    task automatic test_back_to_back();
        logic [15:0] vals [4];
        for (int i = 0; i < 4; i++) begin
            vals[i] = 16'hC000 + 16'(i * 'h111);
            preload(0, 'h40 + i, vals[i]);
        end
        for (int i = 0; i < 4; i++) begin
            req[0] = 1'b1; rd[0] = 1'b1; addr[0] = 16'(16'h0040 + i);
            step();
            checks++;
            if (cmp[0] !== 1'b1 || busy[0] !== 1'b1 || dout[0] !== vals[i]) begin
                failures++;
                $display("FAIL b2b_l1 i=%0d cmp/busy/dout got=%b/%b/%h exp=1/1/%h",
                         i, cmp[0], busy[0], dout[0], vals[i]);
            end
        end
        req[0] = 1'b0;
        pl_en[0] = 1'b1; pl_addr[0] = 8'h43; pl_data[0] = 16'hDEAD;
        step();
        pl_en[0] = 1'b0;
        checks++;
        if (cmp[0] !== 1'b0 || busy[0] !== 1'b0 || dout[0] !== vals[3]) begin
            failures++;
            $display("FAIL b2b_l1_after cmp/busy/dout got=%b/%b/%h exp=0/0/%h",
                     cmp[0], busy[0], dout[0], vals[3]);
        end
        req[0] = 1'b1; rd[0] = 1'b1; addr[0] = 16'h0043;
        step();
        req[0] = 1'b0;
        checks++;
        if (cmp[0] !== 1'b1 || dout[0] !== 16'hDEAD) begin
            failures++;
            $display("FAIL b2b_l1_preload cmp/dout got=%b/%h exp=1/dead", cmp[0], dout[0]);
        end
    endtask

    // Random legal traffic against a transaction-level model: a request taken
    // in cycle t completes in cycle t+lat; a read returns memory as it stood
    // at the start of its completion cycle; end-of-cycle updates apply the
    // completing write first, then the preload.
    task automatic test_random(input int d, input int lat, input int n);
        logic [15:0] exp_dout;
        logic        exp_cmp;
        logic        exp_busy;
        bit          have;
        bit          t_rd;
        int          t_idx;
        logic [15:0] t_din;
        int          t_acc;
        int          t_done;
        bit          issue;
        bit          pl;
        int          pa;
        logic [15:0] pd;

        do_reset(d);
        exp_dout = 16'd0;
        for (int a = 0; a < 256; a++) preload(d, a, 16'($urandom));
        have = 1'b0; t_rd = 1'b0; t_idx = 0; t_din = 16'd0; t_acc = 0; t_done = 0;

        for (int c = 0; c < n; c++) begin
            exp_cmp  = have && (t_done == c);
            exp_busy = have && (c > t_acc) && (c <= t_done);
            if (exp_cmp && t_rd) exp_dout = model_mem[d][t_idx];
            checks++;
            if (cmp[d] !== exp_cmp) begin
                failures++;
                $display("FAIL rand_cmp dut%0d c=%0d got=%b exp=%b", d, c, cmp[d], exp_cmp);
            end
            checks++;
            if (busy[d] !== exp_busy) begin
                failures++;
                $display("FAIL rand_busy dut%0d c=%0d got=%b exp=%b", d, c, busy[d], exp_busy);
            end
            checks++;
            if (dout[d] !== exp_dout) begin
                failures++;
                $display("FAIL rand_dout dut%0d c=%0d got=%h exp=%h", d, c, dout[d], exp_dout);
            end
            checks++;
            if (perr[d] !== 1'b0) begin
                failures++;
                $display("FAIL rand_perr dut%0d c=%0d got=%b exp=0", d, c, perr[d]);
            end

            issue = (!have || (t_done == c)) && ($urandom_range(0, 2) != 0);
            pl    = ($urandom_range(0, 3) == 0);
            pa    = int'($urandom_range(0, 15));
            pd    = 16'($urandom);

            req[d]     = issue;
            rd[d]      = 1'($urandom_range(0, 1));
            addr[d]    = 16'($urandom) & 16'hFF0F;
            din[d]     = 16'($urandom);
            pl_en[d]   = pl;
            pl_addr[d] = 8'(pa);
            pl_data[d] = pd;

            if (have && (t_done == c)) begin
                if (!t_rd) model_mem[d][t_idx] = t_din;
                have = 1'b0;
            end
            if (pl) model_mem[d][pa] = pd;
            if (issue) begin
                have   = 1'b1;
                t_rd   = rd[d];
                t_idx  = int'(addr[d][7:0]);
                t_din  = din[d];
                t_acc  = c;
                t_done = c + lat;
            end
            step();
        end
        idle_inputs(d);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b0;
            idle_inputs(d);
        end
        test_reset();
        test_read_basic();
        test_write_read();
        test_proto_err();
        test_alias();
        test_preload_wins();
        test_reset_abort();
        test_back_to_back();
        test_random(0, 1, 300);
        test_random(1, 2, 300);
        test_random(2, 3, 300);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lc3_dmem_responder.md
# lc3_dmem_responder

Synthesizable data-memory responder for the LC3 pipeline: the memory-side end of the data-memory interface the `dmem` agent drives and monitors. It accepts one read or write request at a time from the LC3 memaccess stage, services it from an internal word array after a fixed, parameterized latency, and signals completion with a one-cycle `complete_data` pulse. It replaces the behavioural memory in the `lc3` bench and gives the `dmem` agent a cycle-accurate responder to check against.

## Interface
- `DEPTH_LOG2`, 8, log2 of memory depth in 16-bit words (256 words).
- `LATENCY`, 2, cycles from request acceptance to completion; legal range 1..15.
- `clock`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_req`  in  1  request strobe from the memaccess stage.
- `Data_rd`  in  1  1 = read, 0 = write; sampled with `data_req`.
- `Data_addr`  in  16  word address; sampled with `data_req`.
- `Data_din`  in  16  write data; sampled with `data_req`.
- `Data_dout`  out  16  read data; valid while `complete_data` is high for a read.
- `complete_data`  out  1  one-cycle completion pulse.
- `busy`  out  1  high while a request is outstanding.
- `proto_err`  out  1  sticky; set when `data_req` arrives while busy.
- `preload_en`  in  1  bench backdoor write enable.
- `preload_addr`  in  DEPTH_LOG2  backdoor address.
- `preload_data`  in  16  backdoor data.

## Operation
- States: IDLE, WAIT.
- IDLE: `data_req`=1 → latch `Data_rd`, `Data_addr[DEPTH_LOG2-1:0]`, `Data_din`; load down-counter with `LATENCY`; go to WAIT; `busy`=1 from the next cycle.
- WAIT: decrement the counter each cycle. When it reaches 1, assert `complete_data` for the next cycle, then return to IDLE.
- On the completion cycle:
  - Read: `Data_dout` ← mem[addr]. The value is held after the cycle until the next read completion.
  - Write: mem[addr] ← latched data at the end of the completion cycle. `Data_dout` is unchanged.
- A `data_req` in the completion cycle is accepted as a new request. This gives back-to-back throughput of one request per `LATENCY` cycles.
- A `data_req` in WAIT other than the completion cycle is ignored and sets `proto_err`. `proto_err` clears only on reset.
- Address bits above `DEPTH_LOG2` are ignored, so addresses alias; e.g. 0x0105 maps to word 0x05 at the default depth.
- `preload_en` writes memory in any state and does not affect the FSM.
  - If it targets the same word as a completing write, preload wins.
  - If it targets the same word as a completing read, the read returns the old value (read-before-write).
- Reset:
  - Outputs: `Data_dout`=0, `complete_data`=0, `busy`=0, `proto_err`=0.
  - FSM goes to IDLE and the counter clears.
  - Memory contents are NOT cleared.
  - Reset during WAIT aborts the request: no completion pulse, no memory write.

## Timing
- Cycle 0 is the cycle `data_req` is sampled high in IDLE.
- `complete_data` is high exactly in cycle `LATENCY`, and is never high for two consecutive cycles unless back-to-back requests with `LATENCY`=1.
- `busy` is high in cycles 1..`LATENCY`. It stays high into cycle `LATENCY`+1 only if a new request was accepted in cycle `LATENCY`.
- Read data is registered and appears together with `complete_data`; there is no combinational path from inputs to outputs.
- Preload takes effect at the end of the cycle `preload_en` is high; a read completing in a later cycle observes it.
- Counter width is 4 bits. `LATENCY` outside 1..15 is a configuration error and is flagged by an elaboration-time assertion.

## Test plan
- Preload word 0x10 = 0xBEEF. With `LATENCY`=2, read addr 0x0010 in cycle 0 → `complete_data`=1 in cycle 2 only, `Data_dout`=0xBEEF; `busy` is high in cycles 1–2.
- Write 0x1234 to 0x0020, then read 0x0020 in the completion cycle of the write → second completion returns 0x1234, 2 cycles later; `proto_err` stays 0.
- With `LATENCY`=3, issue a request in cycle 0 and pulse `data_req` again in cycle 1 → `proto_err`=1 from cycle 2 onward; only one completion, in cycle 3.
- Write 0xAAAA to 0x0105, then read 0x0005 → returns 0xAAAA (aliasing).
- Issue a write of 0x5555 to 0x30 (old value 0x0001) and assert `reset` in cycle 1 → no `complete_data`; all outputs 0; a later read of 0x30 returns 0x0001.
- With `LATENCY`=1, run 4 back-to-back reads → `complete_data` high in cycles 1–4 with data in address order; preload to the last read's address in its completion cycle → old value is returned.
